// File: rtl/imdct_pkg.sv
// rtl/imdct_pkg.sv - shared defaults, FSM state and sample type for the IMDCT block reader
package imdct_pkg;

  localparam int SAMPLE_W  = 18;
  localparam int BLOCK_LEN = 18;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  typedef logic [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/imdct_block_reader_if.sv
// rtl/imdct_block_reader_if.sv - parallel block load and serial sample stream bundle
interface imdct_block_reader_if #(
  parameter int N     = imdct_pkg::SAMPLE_W,
  parameter int COUNT = imdct_pkg::BLOCK_LEN,
  localparam int IDXW = $clog2(COUNT)
);

  logic                 loadEnable;
  logic                 loadReady;
  logic [COUNT*N-1:0]   dataIn;
  logic [N-1:0]         dataOut;
  logic                 outValid;
  logic                 outReady;
  logic                 outLast;
  logic [IDXW-1:0]      outIndex;

  // master: block writer plus downstream consumer; slave: the block reader
  modport master (
    output loadEnable, dataIn, outReady,
    input  loadReady, dataOut, outValid, outLast, outIndex
  );

  modport slave (
    input  loadEnable, dataIn, outReady,
    output loadReady, dataOut, outValid, outLast, outIndex
  );

endinterface

// File: rtl/imdct_sample_bank.sv
// rtl/imdct_sample_bank.sv - COUNT x N register array with parallel load and indexed read
module imdct_sample_bank
  import imdct_pkg::*;
#(
  parameter int N     = SAMPLE_W,
  parameter int COUNT = BLOCK_LEN,
  localparam int IDXW = $clog2(COUNT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [COUNT*N-1:0] din,
  input  logic [IDXW-1:0]    rd_idx,
  output logic [N-1:0]       rd_data
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(COUNT - 1);

  logic [N-1:0] mem [COUNT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < COUNT; k++) mem[k] <= '0;
    end else if (load) begin
      for (int k = 0; k < COUNT; k++) mem[k] <= din[k*N +: N];
    end
  end

  // guard keeps non-power-of-two depths from reading past the array
  always_comb begin
    rd_data = '0;
    if (rd_idx <= LAST_IDX) rd_data = mem[rd_idx];
  end

endmodule

// File: rtl/imdct_block_reader.sv
// rtl/imdct_block_reader.sv - captures a parallel sample block and streams it out one sample per cycle
module imdct_block_reader
  import imdct_pkg::*;
#(
  parameter int N     = SAMPLE_W,
  parameter int COUNT = BLOCK_LEN,
  localparam int IDXW = $clog2(COUNT)
) (
  input  logic                 clk,
  input  logic                 rst,
  imdct_block_reader_if.slave  bus
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(COUNT - 1);

  state_t          state, state_next;
  logic [IDXW-1:0] idx, idx_next;
  logic [N-1:0]    data, data_next;
  logic [N-1:0]    bank_data;
  logic [IDXW-1:0] rd_idx;
  logic            last;
  logic            xfer;
  logic            load;

  assign last          = (idx == LAST_IDX);
  assign bus.outValid  = (state == STREAM);
  assign bus.outLast   = bus.outValid && last;
  assign bus.outIndex  = idx;
  assign bus.dataOut   = data;
  assign xfer          = bus.outValid && bus.outReady;
  // last-beat acceptance lets the next block start with no bubble
  assign bus.loadReady = (state == IDLE) || (bus.outLast && bus.outReady);
  assign load          = bus.loadEnable && bus.loadReady;
  assign rd_idx        = last ? '0 : IDXW'(idx + 1'b1);

  imdct_sample_bank #(
    .N     (N),
    .COUNT (COUNT)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .din     (bus.dataIn),
    .rd_idx  (rd_idx),
    .rd_data (bank_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
      data  <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      data  <= data_next;
    end
  end

  // sample 0 comes straight from dataIn since the bank is written on the same edge
  always_comb begin
    state_next = state;
    idx_next   = idx;
    data_next  = data;
    case (state)
      IDLE: begin
        if (load) begin
          state_next = STREAM;
          idx_next   = '0;
          data_next  = bus.dataIn[N-1:0];
        end
      end
      STREAM: begin
        if (load) begin
          idx_next  = '0;
          data_next = bus.dataIn[N-1:0];
        end else if (xfer) begin
          if (last) begin
            state_next = IDLE;
            idx_next   = '0;
            data_next  = '0;
          end else begin
            idx_next  = IDXW'(idx + 1'b1);
            data_next = bank_data;
          end
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
        data_next  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_imdct_block_reader.sv
// tb/tb_imdct_block_reader.sv - directed and scoreboard checks for imdct_block_reader
module tb_imdct_block_reader;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  imdct_block_reader_if #(.N(18), .COUNT(18)) bus ();
  imdct_block_reader_if #(.N(24), .COUNT(6))  bus2 ();

  imdct_block_reader #(.N(18), .COUNT(18)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  imdct_block_reader #(.N(24), .COUNT(6)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  logic [18*18-1:0] blk;
  logic [17:0]      exp_s [18];

  task automatic test_reset;
    rst = 1'b0;
    bus.loadEnable = 1'b0; bus.outReady = 1'b0; bus.dataIn = '0;
    bus2.loadEnable = 1'b0; bus2.outReady = 1'b0; bus2.dataIn = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.loadReady !== 1'b1) $display("FAIL reset_loadReady: got %b expected 1", bus.loadReady); else passed++;
    total++; if (bus.outValid !== 1'b0) $display("FAIL reset_outValid: got %b expected 0", bus.outValid); else passed++;
    total++; if (bus.dataOut !== 18'd0) $display("FAIL reset_dataOut: got %h expected 0", bus.dataOut); else passed++;
    total++; if (bus.outIndex !== 5'd0) $display("FAIL reset_outIndex: got %0d expected 0", bus.outIndex); else passed++;
    total++; if (bus.outLast !== 1'b0) $display("FAIL reset_outLast: got %b expected 0", bus.outLast); else passed++;
    rst = 1'b1;
    @(posedge clk); #1;
    bus.outReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.outValid !== 1'b0) $display("FAIL idle_ready_outValid: got %b expected 0", bus.outValid); else passed++;
    total++; if (bus.dataOut !== 18'd0) $display("FAIL idle_ready_dataOut: got %h expected 0", bus.dataOut); else passed++;
    total++; if (bus.outIndex !== 5'd0) $display("FAIL idle_ready_outIndex: got %0d expected 0", bus.outIndex); else passed++;
    total++; if (bus.loadReady !== 1'b1) $display("FAIL idle_ready_loadReady: got %b expected 1", bus.loadReady); else passed++;
    bus.outReady = 1'b0;
  endtask

  task automatic test_single_block;
    for (int k = 0; k < 18; k++) begin
      exp_s[k] = 18'(k + 1);
      blk[k*18 +: 18] = exp_s[k];
    end
    bus.dataIn = blk; bus.loadEnable = 1'b1; bus.outReady = 1'b1;
    @(posedge clk); #1;
    bus.loadEnable = 1'b0;
    for (int k = 0; k < 18; k++) begin
      total++; if (bus.outValid !== 1'b1) $display("FAIL single_valid[%0d]: got %b expected 1", k, bus.outValid); else passed++;
      total++; if (bus.dataOut !== exp_s[k]) $display("FAIL single_data[%0d]: got %h expected %h", k, bus.dataOut, exp_s[k]); else passed++;
      total++; if (bus.outIndex !== 5'(k)) $display("FAIL single_index[%0d]: got %0d expected %0d", k, bus.outIndex, k); else passed++;
      total++; if (bus.outLast !== (k == 17)) $display("FAIL single_last[%0d]: got %b expected %b", k, bus.outLast, (k == 17)); else passed++;
      @(posedge clk); #1;
    end
    total++; if (bus.outValid !== 1'b0) $display("FAIL single_end_valid: got %b expected 0", bus.outValid); else passed++;
    total++; if (bus.dataOut !== 18'd0) $display("FAIL single_end_data: got %h expected 0", bus.dataOut); else passed++;
  endtask

  task automatic test_backpressure;
    int e;
    int stall;
    int guard;
    logic rdy;
    for (int k = 0; k < 18; k++) begin
      exp_s[k] = (k == 0) ? 18'h3FFFF : 18'(k);
      blk[k*18 +: 18] = exp_s[k];
    end
    bus.dataIn = blk; bus.loadEnable = 1'b1; bus.outReady = 1'b1;
    @(posedge clk); #1;
    bus.loadEnable = 1'b0;
    e = 0; stall = 0; guard = 0;
    while (e < 18 && guard < 40) begin
      guard++;
      total++; if (bus.outValid !== 1'b1) $display("FAIL bp_valid[%0d]: got %b expected 1", e, bus.outValid); else passed++;
      total++; if (bus.dataOut !== exp_s[e]) $display("FAIL bp_data[%0d]: got %h expected %h", e, bus.dataOut, exp_s[e]); else passed++;
      total++; if (bus.outIndex !== 5'(e)) $display("FAIL bp_index: got %0d expected %0d", bus.outIndex, e); else passed++;
      total++; if (bus.outLast !== (e == 17)) $display("FAIL bp_last[%0d]: got %b expected %b", e, bus.outLast, (e == 17)); else passed++;
      rdy = !(e == 5 && stall < 3);
      if (!rdy) stall++;
      bus.outReady = rdy;
      @(posedge clk); #1;
      if (rdy) e++;
    end
    total++; if (e != 18 || stall != 3) $display("FAIL bp_progress: got e=%0d stall=%0d expected e=18 stall=3", e, stall); else passed++;
    total++; if (bus.outValid !== 1'b0) $display("FAIL bp_end_valid: got %b expected 0", bus.outValid); else passed++;
    bus.outReady = 1'b1;
  endtask

  task automatic test_back_to_back;
    logic [18*18-1:0] blk_b;
    logic [18*18-1:0] blk_junk;
    for (int k = 0; k < 18; k++) begin
      blk[k*18 +: 18]      = 18'(100 + k);
      blk_b[k*18 +: 18]    = 18'(200 + k);
      blk_junk[k*18 +: 18] = 18'h2AAAA;
    end
    bus.dataIn = blk; bus.loadEnable = 1'b1; bus.outReady = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 18; k++) begin
      bus.loadEnable = 1'b0;
      bus.dataIn = blk;
      total++; if (bus.dataOut !== 18'(100 + k) || bus.outValid !== 1'b1) $display("FAIL b2b_a_data[%0d]: got %h/%b expected %h/1", k, bus.dataOut, bus.outValid, 18'(100 + k)); else passed++;
      total++; if (bus.outIndex !== 5'(k)) $display("FAIL b2b_a_index: got %0d expected %0d", bus.outIndex, k); else passed++;
      if (k == 7) begin
        bus.loadEnable = 1'b1; bus.dataIn = blk_junk;
        #1;
        total++; if (bus.loadReady !== 1'b0) $display("FAIL b2b_mid_loadReady: got %b expected 0", bus.loadReady); else passed++;
      end
      if (k == 17) begin
        bus.loadEnable = 1'b1; bus.dataIn = blk_b;
        #1;
        total++; if (bus.loadReady !== 1'b1) $display("FAIL b2b_last_loadReady: got %b expected 1", bus.loadReady); else passed++;
      end
      @(posedge clk); #1;
    end
    bus.loadEnable = 1'b0;
    for (int k = 0; k < 18; k++) begin
      total++; if (bus.dataOut !== 18'(200 + k) || bus.outValid !== 1'b1) $display("FAIL b2b_b_data[%0d]: got %h/%b expected %h/1", k, bus.dataOut, bus.outValid, 18'(200 + k)); else passed++;
      total++; if (bus.outIndex !== 5'(k)) $display("FAIL b2b_b_index: got %0d expected %0d", bus.outIndex, k); else passed++;
      @(posedge clk); #1;
    end
    total++; if (bus.outValid !== 1'b0) $display("FAIL b2b_end_valid: got %b expected 0", bus.outValid); else passed++;
  endtask

  task automatic test_reset_mid_stream;
    for (int k = 0; k < 18; k++) blk[k*18 +: 18] = 18'(300 + k);
    bus.dataIn = blk; bus.loadEnable = 1'b1; bus.outReady = 1'b1;
    @(posedge clk); #1;
    bus.loadEnable = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    total++; if (bus.outIndex !== 5'd9 || bus.dataOut !== 18'(309)) $display("FAIL rm_pre: got idx %0d data %h expected 9/%h", bus.outIndex, bus.dataOut, 18'(309)); else passed++;
    #1 rst = 1'b0;
    #1;
    total++; if (bus.outValid !== 1'b0) $display("FAIL rm_outValid: got %b expected 0", bus.outValid); else passed++;
    total++; if (bus.dataOut !== 18'd0) $display("FAIL rm_dataOut: got %h expected 0", bus.dataOut); else passed++;
    total++; if (bus.loadReady !== 1'b1) $display("FAIL rm_loadReady: got %b expected 1", bus.loadReady); else passed++;
    total++; if (bus.outIndex !== 5'd0) $display("FAIL rm_outIndex: got %0d expected 0", bus.outIndex); else passed++;
    #1 rst = 1'b1;
    for (int k = 0; k < 18; k++) blk[k*18 +: 18] = 18'(400 + k);
    bus.dataIn = blk; bus.loadEnable = 1'b1;
    @(posedge clk); #1;
    bus.loadEnable = 1'b0;
    for (int k = 0; k < 18; k++) begin
      total++; if (bus.dataOut !== 18'(400 + k) || bus.outIndex !== 5'(k) || bus.outValid !== 1'b1) $display("FAIL rm_new[%0d]: got %h/%0d expected %h/%0d", k, bus.dataOut, bus.outIndex, 18'(400 + k), k); else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sweep;
    logic [23:0] q[$];
    logic        m_valid;
    int          m_idx;
    int          loads;
    int          pops;
    logic        rdy, le, m_lr;
    logic [6*24-1:0] din;
    m_valid = 1'b0; m_idx = 0; loads = 0; pops = 0;
    for (int c = 0; c < 400; c++) begin
      total++; if (bus2.outValid !== m_valid) $display("FAIL sw_valid[%0d]: got %b expected %b", c, bus2.outValid, m_valid); else passed++;
      if (m_valid) begin
        total++; if (bus2.dataOut !== q[0]) $display("FAIL sw_data[%0d]: got %h expected %h", c, bus2.dataOut, q[0]); else passed++;
        total++; if (bus2.outIndex !== 3'(m_idx)) $display("FAIL sw_index[%0d]: got %0d expected %0d", c, bus2.outIndex, m_idx); else passed++;
        total++; if (bus2.outLast !== (m_idx == 5)) $display("FAIL sw_last[%0d]: got %b expected %b", c, bus2.outLast, (m_idx == 5)); else passed++;
      end
      rdy = (c >= 380) ? 1'b1 : ($urandom_range(0, 3) != 0);
      le  = (c >= 370) ? 1'b0 : ($urandom_range(0, 2) == 0);
      for (int k = 0; k < 6; k++) din[k*24 +: 24] = 24'($urandom);
      bus2.outReady = rdy; bus2.loadEnable = le; bus2.dataIn = din;
      m_lr = !m_valid || (m_idx == 5 && rdy);
      #1;
      total++; if (bus2.loadReady !== m_lr) $display("FAIL sw_loadReady[%0d]: got %b expected %b", c, bus2.loadReady, m_lr); else passed++;
      if (m_valid && rdy) begin
        void'(q.pop_front());
        pops++;
        if (m_idx == 5) begin m_valid = 1'b0; m_idx = 0; end
        else m_idx++;
      end
      if (le && m_lr) begin
        for (int k = 0; k < 6; k++) q.push_back(din[k*24 +: 24]);
        m_valid = 1'b1; m_idx = 0; loads++;
      end
      @(posedge clk); #1;
    end
    bus2.loadEnable = 1'b0;
    total++; if (q.size() != 0 || bus2.outValid !== 1'b0) $display("FAIL sw_drain: got %0d pending valid %b expected 0/0", q.size(), bus2.outValid); else passed++;
    total++; if (pops != loads * 6 || loads < 5) $display("FAIL sw_count: got %0d pops %0d loads expected pops=6*loads", pops, loads); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_stream();
    test_sweep();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
